// File: rtl/row_fetch_ctrl.sv
// Row-fetch scheduler: keeps the four source rows of a window resident in a
// 4-slot line-buffer ring, fetching missing rows from frame memory.
module row_fetch_ctrl #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        wr_req,
  input  logic [11:0] dst_row,
  output logic        tran_done,
  output logic        busy,
  output logic        req_err,
  output logic [1:0]  sel_x1,
  output logic [1:0]  sel_x2,
  output logic [1:0]  sel_x3,
  output logic [1:0]  sel_x4,
  output logic        mem_req,
  output logic [11:0] mem_row,
  input  logic        mem_ack,
  input  logic        mem_vld,
  input  logic [15:0] mem_data,
  output logic        lb_we,
  output logic [1:0]  lb_slot,
  output logic [11:0] lb_waddr,
  output logic [15:0] lb_wdata
);

  localparam logic [11:0] LastCol = 12'(IMG_W - 1);
  localparam logic [11:0] LastRow = 12'(IMG_H - 1);

  typedef enum logic [2:0] {StIdle, StCheck, StReq, StLoad, StDone} state_e;

  state_e      state_q, state_d;
  logic [11:0] row_q;
  logic [11:0] mem_row_q;
  logic [11:0] col_q;
  logic        req_err_q;
  logic [3:0]  tag_vld_q;
  logic [11:0] tag_row_q [4];
  logic [1:0]  sel_q [4];

  logic [11:0] need [4];
  logic [3:0]  hit;
  logic        miss_any;
  logic [11:0] miss_row;
  logic        load_wr;

  // Needed rows, clamped to the image; row_q never exceeds LastRow.
  always_comb begin
    need[0] = (row_q == 12'd0) ? 12'd0 : row_q - 12'd1;
    need[1] = row_q;
    need[2] = (row_q >= LastRow) ? LastRow : row_q + 12'd1;
    need[3] = (row_q >= LastRow - 12'd1) ? LastRow : row_q + 12'd2;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      hit[k] = tag_vld_q[need[k][1:0]] && (tag_row_q[need[k][1:0]] == need[k]);
    end
    miss_any = ~&hit;
    miss_row = need[3];
    // Walk backwards so the lowest-index miss wins.
    for (int k = 3; k >= 0; k--) begin
      if (!hit[k]) miss_row = need[k];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!flush && wr_req && dst_row <= LastRow) state_d = StCheck;
      StCheck: state_d = miss_any ? StReq : StDone;
      StReq:   if (mem_ack) state_d = StLoad;
      StLoad:  if (mem_vld && col_q == LastCol) state_d = StCheck;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; line-buffer writes pass straight through
  always_comb begin
    busy      = (state_q != StIdle);
    tran_done = (state_q == StDone);
    mem_req   = (state_q == StReq);
    load_wr   = (state_q == StLoad) && mem_vld;
    lb_we     = load_wr;
    lb_slot   = load_wr ? mem_row_q[1:0] : 2'd0;
    lb_waddr  = load_wr ? col_q : 12'd0;
    lb_wdata  = load_wr ? mem_data : 16'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q     <= '0;
      mem_row_q <= '0;
      col_q     <= '0;
      req_err_q <= 1'b0;
      tag_vld_q <= '0;
      for (int k = 0; k < 4; k++) begin
        tag_row_q[k] <= '0;
        sel_q[k]     <= '0;
      end
    end else begin
      req_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (flush) begin
            tag_vld_q <= '0;
          end else if (wr_req) begin
            if (dst_row <= LastRow) row_q <= dst_row;
            else                    req_err_q <= 1'b1;
          end
        end
        StCheck: begin
          if (miss_any) begin
            mem_row_q <= miss_row;
          end else begin
            for (int k = 0; k < 4; k++) sel_q[k] <= need[k][1:0];
          end
        end
        StReq: begin
          if (mem_ack) begin
            tag_vld_q[mem_row_q[1:0]] <= 1'b0;
            col_q                     <= '0;
          end
        end
        StLoad: begin
          if (mem_vld) begin
            col_q <= col_q + 12'd1;
            if (col_q == LastCol) begin
              tag_vld_q[mem_row_q[1:0]] <= 1'b1;
              tag_row_q[mem_row_q[1:0]] <= mem_row_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign req_err = req_err_q;
  assign mem_row = mem_row_q;
  assign sel_x1  = sel_q[0];
  assign sel_x2  = sel_q[1];
  assign sel_x3  = sel_q[2];
  assign sel_x4  = sel_q[3];

endmodule

// File: tb/tb_row_fetch_ctrl.sv
// Directed bench for row_fetch_ctrl with a small frame, a 1-cycle-ack memory
// model streaming row*16+col, and a scoreboard of expected fetches and writes.
module tb_row_fetch_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned H = 6;

  logic        clk, rstn, flush, wr_req;
  logic [11:0] dst_row;
  logic        tran_done, busy, req_err;
  logic [1:0]  sel_x1, sel_x2, sel_x3, sel_x4;
  logic        mem_req, mem_ack, mem_vld;
  logic [11:0] mem_row;
  logic [15:0] mem_data;
  logic        lb_we;
  logic [1:0]  lb_slot;
  logic [11:0] lb_waddr;
  logic [15:0] lb_wdata;

  row_fetch_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .wr_req(wr_req), .dst_row(dst_row),
    .tran_done(tran_done), .busy(busy), .req_err(req_err),
    .sel_x1(sel_x1), .sel_x2(sel_x2), .sel_x3(sel_x3), .sel_x4(sel_x4),
    .mem_req(mem_req), .mem_row(mem_row), .mem_ack(mem_ack), .mem_vld(mem_vld),
    .mem_data(mem_data), .lb_we(lb_we), .lb_slot(lb_slot), .lb_waddr(lb_waddr),
    .lb_wdata(lb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int mreq_cyc = 0;
  int unsigned stall_n = 0;

  logic [29:0] wq [$];
  logic [11:0] rq [$];

  function automatic void check(input string tag, input logic [31:0] obs,
                                input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endfunction

  // Memory model: ack after stall_n request cycles, then W words, one per cycle.
  logic [11:0] s_row;
  int unsigned s_cnt;
  logic        s_act;
  int unsigned wait_cnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_ack  <= 1'b0;
      mem_vld  <= 1'b0;
      mem_data <= '0;
      s_row    <= '0;
      s_cnt    <= 0;
      s_act    <= 1'b0;
      wait_cnt <= 0;
    end else begin
      wait_cnt <= mem_req ? wait_cnt + 1 : 0;
      mem_ack  <= mem_req && !mem_ack && (wait_cnt >= stall_n);
      if (mem_req && mem_ack) begin
        s_row   <= mem_row;
        s_cnt   <= 0;
        s_act   <= 1'b1;
        mem_vld <= 1'b0;
      end else if (s_act) begin
        mem_vld  <= 1'b1;
        mem_data <= 16'({4'd0, s_row} * 16'd16 + 16'(s_cnt));
        s_cnt    <= s_cnt + 1;
        if (s_cnt == W - 1) s_act <= 1'b0;
      end else begin
        mem_vld <= 1'b0;
      end
    end
  end

  // Scoreboard side: compare writes and accepted row requests as they appear.
  always @(negedge clk) begin
    if (rstn) begin
      if (lb_we) begin
        we_cnt++;
        if (wq.size() == 0) check("lb_we_unexpected", 32'(lb_we), 32'(0));
        else check("lb_write", 32'({lb_slot, lb_waddr, lb_wdata}), 32'(wq.pop_front()));
      end
      if (mem_req && mem_ack) begin
        if (rq.size() == 0) check("mem_req_unexpected", 32'(mem_req), 32'(0));
        else check("mem_row", 32'(mem_row), 32'(rq.pop_front()));
      end
      if (mem_req) mreq_cyc++;
      if (tran_done) done_cnt++;
    end
  end

  task automatic exp_fetch(input int r);
    logic [11:0] rr;
    rr = 12'(r);
    rq.push_back(rr);
    for (int c = 0; c < W; c++) wq.push_back({rr[1:0], 12'(c), 16'(r * 16 + c)});
  endtask

  task automatic pulse_req(input logic [11:0] r);
    @(negedge clk);
    wr_req  = 1'b1;
    dst_row = r;
    @(negedge clk);
    wr_req  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [7:0] want_sel);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tran_done) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(found), 32'(1));
    check({tag, "_sel"}, 32'({sel_x1, sel_x2, sel_x3, sel_x4}), 32'(want_sel));
    check({tag, "_wq_left"}, 32'(wq.size()), 32'(0));
    check({tag, "_rq_left"}, 32'(rq.size()), 32'(0));
    @(negedge clk);
    check({tag, "_busy_fall"}, 32'(busy), 32'(0));
  endtask

  task automatic wait_we(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (lb_we) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_we_seen"}, 32'(found), 32'(1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({tran_done, busy, req_err, mem_req, lb_we}), 32'(0));
    check({tag, "_mem_row"}, 32'(mem_row), 32'(0));
    check({tag, "_sel"}, 32'({sel_x1, sel_x2, sel_x3, sel_x4}), 32'(0));
    check({tag, "_lb"}, 32'({lb_slot, lb_waddr, lb_wdata}), 32'(0));
  endtask

  initial begin
    int we0, d0, m0;
    logic [11:0] r0;
    logic seen;
    rstn = 1'b0; flush = 1'b0; wr_req = 1'b0; dst_row = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Cold start: rows 0,1,2 fetched, 12 writes
    we0 = we_cnt; d0 = done_cnt;
    exp_fetch(0); exp_fetch(1); exp_fetch(2);
    pulse_req(12'd0);
    wait_done("cold", 8'b00_00_01_10);
    check("cold_we_count", 32'(we_cnt - we0), 32'(12));
    check("cold_done_count", 32'(done_cnt - d0), 32'(1));

    exp_fetch(3);
    pulse_req(12'd1);
    wait_done("row1", 8'b00_01_10_11);

    exp_fetch(4);
    pulse_req(12'd2);
    wait_done("row2", 8'b01_10_11_00);

    exp_fetch(5);
    pulse_req(12'd4);
    wait_done("row4", 8'b11_00_01_01);

    // Bottom clamp, all hits: tran_done exactly two cycles after wr_req
    m0 = mreq_cyc;
    for (int k = 0; k < 2; k++) begin
      pulse_req(12'd5);
      check("hit_lat_early", 32'(tran_done), 32'(0));
      @(negedge clk);
      check("hit_lat_done", 32'(tran_done), 32'(1));
      check("hit_sel", 32'({sel_x1, sel_x2, sel_x3, sel_x4}), 32'(8'b00_01_01_01));
      @(negedge clk);
      check("hit_busy_fall", 32'(busy), 32'(0));
    end
    check("hit_no_mem_req", 32'(mreq_cyc - m0), 32'(0));

    // Out-of-range row
    m0 = mreq_cyc;
    pulse_req(12'd6);
    check("err_pulse", 32'({req_err, busy}), 32'(2'b10));
    @(negedge clk);
    check("err_clear", 32'({req_err, busy}), 32'(2'b00));
    check("err_no_mem_req", 32'(mreq_cyc - m0), 32'(0));

    // wr_req while loading is ignored
    d0 = done_cnt;
    exp_fetch(0); exp_fetch(1);
    pulse_req(12'd1);
    wait_we("busy_req");
    wr_req = 1'b1; dst_row = 12'd3;
    @(negedge clk);
    wr_req = 1'b0;
    wait_done("busy_req", 8'b00_01_10_11);
    repeat (4) @(negedge clk);
    check("busy_req_one_done", 32'(done_cnt - d0), 32'(1));

    // flush beats a same-cycle wr_req
    d0 = done_cnt;
    @(negedge clk);
    flush = 1'b1; wr_req = 1'b1; dst_row = 12'd1;
    @(negedge clk);
    flush = 1'b0; wr_req = 1'b0;
    check("flush_drop_busy", 32'(busy), 32'(0));
    @(negedge clk);
    check("flush_drop_idle", 32'({busy, 1'b0}), 32'(0));
    check("flush_drop_done", 32'(done_cnt - d0), 32'(0));

    // After flush all four rows refetched; first ack withheld
    stall_n = 5;
    exp_fetch(0); exp_fetch(1); exp_fetch(2); exp_fetch(3);
    pulse_req(12'd1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("stall_req_seen", 32'(seen), 32'(1));
    r0 = mem_row;
    check("stall_first_row", 32'(r0), 32'(0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", 32'({mem_req, mem_row}), 32'({1'b1, r0}));
    end
    stall_n = 0;
    wait_done("flush_refetch", 8'b00_01_10_11);

    // Reset in the middle of a row load
    exp_fetch(4);
    pulse_req(12'd3);
    wait_we("rst_mid");
    rstn = 1'b0;
    #1;
    check_zero("rst_mid");
    wq.delete();
    rq.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    exp_fetch(0); exp_fetch(1); exp_fetch(2); exp_fetch(3);
    pulse_req(12'd1);
    wait_done("post_rst", 8'b00_01_10_11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
